// File: rtl/dds_sine_gen.sv
// dds_sine_gen: DDS tone generator that drives a quarter-wave sine ROM.
//
// A phase accumulator advances by the frequency word on every enabled sample tick. The current
// phase is folded into a quarter-wave ROM address plus a sign bit. After the ROM read latency,
// the unsigned magnitude is turned into a signed full-wave sample on a valid/ready output.
//
// Ports:
//   clk_i          single clock
//   rst_ni         asynchronous active-low reset
//   en_i           generator enable; low clears phase and overrun, ignores ticks
//   freq_word_i    phase increment per sample
//   freq_load_i    one-cycle strobe capturing freq_word_i
//   sample_tick_i  one-cycle audio sample-rate strobe
//   rom_addr_o     registered quarter-wave ROM address
//   rom_data_i     ROM magnitude, valid ROM_LAT cycles after rom_addr_o changes
//   out_data_o     signed output sample
//   out_valid_o    out_data_o is valid
//   out_ready_i    consumer accepts out_data_o
//   overrun_o      sticky: a tick arrived while the previous sample was still pending
module dds_sine_gen #(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned ROM_AW  = 10,
   parameter int unsigned ROM_DW  = 15,
   parameter int unsigned ROM_LAT = 2,
   parameter int unsigned OUT_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic [PHASE_W-1:0] freq_word_i,
   input  logic               freq_load_i,
   input  logic               sample_tick_i,
   output logic [ROM_AW-1:0]  rom_addr_o,
   input  logic [ROM_DW-1:0]  rom_data_i,
   output logic [OUT_W-1:0]   out_data_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic               overrun_o
);

   typedef enum logic [1:0] {StIdle, StLookup, StHold} state_e;

   localparam int unsigned LatW = 3;
   localparam logic [LatW-1:0] LatInit = LatW'(ROM_LAT);
   localparam logic [LatW-1:0] LatOne  = LatW'(1);

   state_e              state_q;
   logic [PHASE_W-1:0]  fw_q;
   logic [PHASE_W-1:0]  phase_q;
   logic [LatW-1:0]     lat_cnt_q;
   logic                sign_q;
   logic [ROM_AW-1:0]   rom_addr_q;
   logic [OUT_W-1:0]    out_data_q;
   logic                out_valid_q;
   logic                overrun_q;

   logic [1:0]          quad;
   logic [ROM_AW-1:0]   idx;
   logic [ROM_AW-1:0]   fold_addr;
   logic [OUT_W-1:0]    mag_ext;
   logic [OUT_W-1:0]    sample;

   // Fold the pre-increment phase: odd quadrants read the ROM backwards, the upper half is negated.
   always_comb begin
      quad      = phase_q[PHASE_W-1 -: 2];
      idx       = phase_q[PHASE_W-3 -: ROM_AW];
      fold_addr = quad[0] ? ~idx : idx;
      mag_ext   = {{(OUT_W - ROM_DW){1'b0}}, rom_data_i};
      sample    = sign_q ? (OUT_W'(0) - mag_ext) : mag_ext;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         fw_q        <= '0;
         phase_q     <= '0;
         lat_cnt_q   <= '0;
         sign_q      <= 1'b0;
         rom_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (freq_load_i) begin
            fw_q <= freq_word_i;
         end

         // Phase keeps advancing even when a sample is dropped so the pitch stays exact.
         if (!en_i) begin
            phase_q <= '0;
         end else if (sample_tick_i) begin
            phase_q <= phase_q + fw_q;
         end

         if (!en_i) begin
            overrun_q <= 1'b0;
         end else if (sample_tick_i && (state_q != StIdle)) begin
            overrun_q <= 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (sample_tick_i && en_i) begin
                  rom_addr_q <= fold_addr;
                  sign_q     <= quad[1];
                  lat_cnt_q  <= LatInit;
                  state_q    <= StLookup;
               end
            end
            StLookup: begin
               lat_cnt_q <= lat_cnt_q - LatOne;
               if (lat_cnt_q == LatOne) begin
                  out_data_q  <= sample;
                  out_valid_q <= 1'b1;
                  state_q     <= StHold;
               end
            end
            StHold: begin
               // A tick coinciding with this handshake was already counted as an overrun above.
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign rom_addr_o  = rom_addr_q;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_dds_sine_gen.sv
// Bench for dds_sine_gen: directed scenarios followed by randomized stimulus, with a
// cycle-level behavioural model feeding a scoreboard queue that a separate monitor checks.
module tb_dds_sine_gen;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        freq_load = 1'b0;
   logic        tick = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] freq_word = '0;
   logic [9:0]  rom_addr;
   logic [14:0] rom_data;
   logic [15:0] out_data;
   logic        out_valid;
   logic        overrun;

   always #5 clk = ~clk;

   dds_sine_gen #(
      .PHASE_W(32),
      .ROM_AW (10),
      .ROM_DW (15),
      .ROM_LAT(LAT),
      .OUT_W  (16)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .en_i         (en),
      .freq_word_i  (freq_word),
      .freq_load_i  (freq_load),
      .sample_tick_i(tick),
      .rom_addr_o   (rom_addr),
      .rom_data_i   (rom_data),
      .out_data_o   (out_data),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .overrun_o    (overrun)
   );

   // Behavioural ROM: identity table or a scaled table, one register stage (data two cycles
   // after the address register updates, counting the address cycle).
   bit rom_mode = 1'b0;

   function automatic logic [14:0] mag(input logic [9:0] a, input bit mode);
      int v;
      v = mode ? (int'(a) * 29 + 3) : int'(a);
      return v[14:0];
   endfunction

   always @(posedge clk) rom_data <= mag(rom_addr, rom_mode);

   typedef struct {
      logic [15:0] data;
      logic [9:0]  addr;
      longint      vcyc;
   } exp_t;

   exp_t        sbq[$];
   longint      cyc = 0;
   int          checks = 0;
   int          passes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: phase arithmetic, quadrant folding by division, and a "sample pending"
   // flag that lasts from acceptance until the handshake cycle.
   logic [31:0] m_phase = '0;
   logic [31:0] m_fw = '0;
   bit          m_pend = 1'b0;
   bit          m_ovr = 1'b0;
   longint      m_vcyc = 0;
   bit          m_hs;
   int          m_quad, m_idx, m_a, m_v;
   exp_t        m_e;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = '0;
         m_fw    = '0;
         m_pend  = 1'b0;
         m_ovr   = 1'b0;
         sbq.delete();
      end else begin
         m_hs = m_pend && (cyc >= m_vcyc) && out_ready;
         if (en && tick) begin
            if (!m_pend) begin
               m_quad = int'(m_phase / 32'h4000_0000);
               m_idx  = int'((m_phase / 32'd1048576) % 32'd1024);
               m_a    = (m_quad % 2 == 1) ? (1023 - m_idx) : m_idx;
               m_v    = int'(mag(m_a[9:0], rom_mode));
               if (m_quad >= 2) m_v = -m_v;
               m_e.data = m_v[15:0];
               m_e.addr = m_a[9:0];
               m_e.vcyc = cyc + 1 + LAT;
               sbq.push_back(m_e);
               m_pend = 1'b1;
               m_vcyc = cyc + 1 + LAT;
            end else begin
               m_ovr = 1'b1;
            end
            m_phase = m_phase + m_fw;
         end
         if (!en) begin
            m_phase = '0;
            m_ovr   = 1'b0;
         end
         if (m_hs) m_pend = 1'b0;
         if (freq_load) m_fw = freq_word;
      end
      cyc++;
   end

   // Monitor: mid-cycle sampling of registered outputs against the model and scoreboard.
   exp_t cur;
   bit   have = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         have = 1'b0;
      end else begin
         check("overrun", overrun, m_ovr);
         check("phase", dut.phase_q, m_phase);
         if (out_valid) begin
            if (!have) begin
               if (sbq.size() == 0) begin
                  check("spurious_valid", out_valid, 0);
               end else begin
                  cur  = sbq.pop_front();
                  have = 1'b1;
                  check("valid_cycle", cyc, cur.vcyc);
               end
            end
            if (have) begin
               check("out_data", out_data, cur.data);
               check("rom_addr", rom_addr, cur.addr);
               if (out_ready) have = 1'b0;
            end
         end else if (sbq.size() > 0 && cyc > sbq[0].vcyc) begin
            check("valid_late", out_valid, 1);
            void'(sbq.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         tick      = 1'b0;
         freq_load = 1'b0;
      end
   endtask

   initial begin
      // Reset state
      step(3);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_overrun", overrun, 0);
      rst_n = 1'b1;

      // fw = 0 tick gives a zero sample
      en = 1'b1;
      out_ready = 1'b1;
      tick = 1'b1;
      step(8);

      // Quadrant folding: 0, +1023, 0, -1023
      freq_word = 32'h4000_0000;
      freq_load = 1'b1;
      step(1);
      repeat (4) begin
         tick = 1'b1;
         step(8);
      end

      // Latency, stalled handshake and overrun
      freq_word = 32'h1234_5678;
      freq_load = 1'b1;
      step(1);
      en = 1'b0;
      step(1);
      en = 1'b1;
      out_ready = 1'b0;
      tick = 1'b1;
      step(5);
      tick = 1'b1;
      step(8);
      check("phase_2fw", dut.phase_q, 32'h2468_ACF0);
      check("overrun_set", overrun, 1);
      out_ready = 1'b1;
      step(2);
      tick = 1'b1;
      step(8);

      // freq_load colliding with a tick uses the old word
      en = 1'b0;
      step(1);
      en = 1'b1;
      freq_word = 32'h1000_0000;
      freq_load = 1'b1;
      step(1);
      freq_word = 32'h2000_0000;
      freq_load = 1'b1;
      tick = 1'b1;
      step(1);
      check("phase_old_fw", dut.phase_q, 32'h1000_0000);
      tick = 1'b1;
      step(1);
      check("phase_new_fw", dut.phase_q, 32'h3000_0000);
      step(8);

      // Enable drop during a lookup
      en = 1'b0;
      step(1);
      en = 1'b1;
      tick = 1'b1;
      step(1);
      en = 1'b0;
      step(1);
      check("en_phase_clr", dut.phase_q, 0);
      check("en_overrun_clr", overrun, 0);
      step(6);
      en = 1'b1;
      tick = 1'b1;
      step(8);

      // Asynchronous reset in the middle of a lookup
      tick = 1'b1;
      step(6);
      tick = 1'b1;
      step(1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_rom_addr", rom_addr, 0);
      check("arst_out_data", out_data, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_overrun", overrun, 0);
      step(2);
      rst_n = 1'b1;
      tick = 1'b1;
      step(8);

      // Randomized traffic with the scaled ROM table
      rom_mode = 1'b1;
      for (int i = 0; i < 600; i++) begin
         tick      = ($urandom_range(0, 3) == 0);
         freq_load = ($urandom_range(0, 15) == 0);
         freq_word = $urandom;
         en        = ($urandom_range(0, 19) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         step(1);
      end

      en = 1'b1;
      out_ready = 1'b1;
      step(12);
      check("scoreboard_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
